if_id_buffer: RTL and testbench
===============================

IF_ID_BUFFER -- requirements
Module: if_id_buffer

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset, with ports named clk and rst as elsewhere in the codebase.
REQ-002 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-004 SHALL have port if_valid_i, input, 1 bit: fetch stage presents an instruction.
REQ-005 SHALL have port if_pc_i, input, 32 bits: address of the presented instruction.
REQ-006 SHALL have port if_inst_i, input, 64 bits: presented instruction ([63:60] access type, [59:52] opcode).
REQ-007 SHALL have port if_ready_o, output, 1 bit: buffer can accept this cycle.
REQ-008 SHALL have port stall_i, input, 1 bit: decode holds its current instruction.
REQ-009 SHALL have port flush_i, input, 1 bit: discard all buffered instructions.
REQ-010 SHALL have port id_valid_o, output, 1 bit: id_pc_o and id_inst_o hold a real instruction.
REQ-011 SHALL have port id_pc_o, output, 32 bits: PC delivered to decode.
REQ-012 SHALL have port id_inst_o, output, 64 bits: instruction delivered to decode.

Function
REQ-013 SHALL be a 2-entry buffer made of an output register (OUT) and a skid register (SKID), with a state machine using the states EMPTY (0 entries), ONE (OUT valid) and FULL (OUT and SKID valid).
REQ-014 SHALL define accept = if_valid_i & if_ready_o and consume = id_valid_o & ~stall_i.
REQ-015 SHALL drive if_ready_o = ~rst & (state != FULL), combinationally.
REQ-016 SHALL make these transitions from EMPTY: on accept, load OUT and go to ONE; otherwise stay in EMPTY.
REQ-017 SHALL make these transitions from ONE: consume&accept loads OUT and stays in ONE; consume only goes to EMPTY; accept only loads SKID and goes to FULL; neither holds.
REQ-018 SHALL make these transitions from FULL: consume moves SKID to OUT and goes to ONE; otherwise hold. No accept is possible in FULL.
REQ-019 SHALL give flush_i priority over all other events: at the next edge go to EMPTY, clear OUT and SKID, and drop any input accepted in that same cycle.
REQ-020 SHALL have a latency of one edge, input to id outputs, when the buffer is in EMPTY or ONE with consume, and SHALL sustain a throughput of 1 instruction/cycle with stall_i low.
REQ-021 SHALL drive id_valid_o=1 exactly in states ONE and FULL.
REQ-022 SHALL hold id_pc_o and id_inst_o at 0 while id_valid_o=0, so that decode sees access type 0 and treats it as a NOP.
REQ-023 SHALL keep id_pc_o and id_inst_o bit-stable during stall_i=1.
REQ-024 SHALL deliver instructions in order, with none lost and none duplicated, except those discarded by flush.
REQ-025 SHALL ignore stall_i while in EMPTY.
REQ-026 SHALL never drive if_ready_o low in response to stall_i alone; it is low only in FULL and during reset.

Reset
REQ-027 SHALL, while rst=1, asynchronously force state EMPTY, OUT=0, SKID=0, id_valid_o=0, id_pc_o=0, id_inst_o=0 and if_ready_o=0.
REQ-028 SHALL, on rst deassertion, start accepting at the first rising edge; an assertion of rst mid-operation discards all entries, the same as a flush.
REQ-029 SHALL give rst precedence over flush_i, stall_i and if_valid_i.

Verification
REQ-030 SHALL be verified by streaming: pc 0x0,0x8,0x10 with instructions A,B,C on consecutive cycles, stall_i=0, so that id outputs show A,B,C on the next three cycles with id_valid_o=1 throughout.
REQ-031 SHALL be verified by skid fill: in ONE holding A, stall_i=1 with B offered, so that B is captured, state becomes FULL, if_ready_o=0 and id_inst_o stays A; on releasing stall, B is output next and if_ready_o=1.
REQ-032 SHALL be verified by flush in FULL: with flush_i=1 and if_valid_i=1 (D), the next cycle shows id_valid_o=0, id_inst_o=0, id_pc_o=0 and D is never delivered.
REQ-033 SHALL be verified by async reset: rst pulsed between clock edges in FULL, so that outputs go to 0 and if_ready_o=0 immediately, and after release the first offered instruction appears one edge later.
REQ-034 SHALL be verified by a long stall: stall_i=1 for 5 cycles in FULL, so that id_pc_o and id_inst_o are constant, if_ready_o=0 throughout, and no input is accepted.
REQ-035 SHALL be verified by random valid/stall/flush for 10k cycles checked against a reference queue, with no reordering, loss or duplication and occupancy never above 2.

Source files
------------

// File: rtl/if_id_buffer.sv
// ---------------------------------------------------------------------------
// if_id_buffer
//   Two-entry elastic buffer between fetch and decode. An output register
//   (OUT) feeds decode directly. A skid register (SKID) catches the one
//   instruction that fetch may push while decode is stalled. Because of SKID,
//   if_ready_o depends only on occupancy and never on stall_i.
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   asynchronous active-high reset
//   if_valid_i  in   fetch presents an instruction
//   if_pc_i     in   [31:0] PC of the presented instruction
//   if_inst_i   in   [63:0] presented instruction ([63:60] access type)
//   if_ready_o  out  buffer accepts this cycle (low only when FULL or in reset)
//   stall_i     in   decode holds its current instruction
//   flush_i     in   discard everything buffered plus this cycle's input
//   id_valid_o  out  id_pc_o / id_inst_o carry a real instruction
//   id_pc_o     out  [31:0] PC to decode (0 when not valid)
//   id_inst_o   out  [63:0] instruction to decode (0 when not valid -> NOP)
// ---------------------------------------------------------------------------
module if_id_buffer (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid_i,
  input  logic [31:0] if_pc_i,
  input  logic [63:0] if_inst_i,
  output logic        if_ready_o,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic        id_valid_o,
  output logic [31:0] id_pc_o,
  output logic [63:0] id_inst_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_out_pc;
  logic [63:0] r_out_inst;
  logic [31:0] r_skid_pc;
  logic [63:0] r_skid_inst;

  logic w_accept;
  logic w_consume;

  assign if_ready_o = ~rst & (r_state != FULL);
  assign w_accept   = if_valid_i & if_ready_o;
  assign w_consume  = id_valid_o & ~stall_i;

  assign id_valid_o = (r_state != EMPTY);
  // OUT is zeroed whenever the buffer drains, so it reads as a NOP when idle.
  assign id_pc_o    = r_out_pc;
  assign id_inst_o  = r_out_inst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= EMPTY;
      r_out_pc    <= '0;
      r_out_inst  <= '0;
      r_skid_pc   <= '0;
      r_skid_inst <= '0;
    end else if (flush_i) begin
      // Flush wins over everything, including an input accepted this cycle.
      r_state     <= EMPTY;
      r_out_pc    <= '0;
      r_out_inst  <= '0;
      r_skid_pc   <= '0;
      r_skid_inst <= '0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            r_out_pc   <= if_pc_i;
            r_out_inst <= if_inst_i;
            r_state    <= ONE;
          end
        end
        ONE: begin
          if (w_consume && w_accept) begin
            r_out_pc   <= if_pc_i;
            r_out_inst <= if_inst_i;
          end else if (w_consume) begin
            r_out_pc   <= '0;
            r_out_inst <= '0;
            r_state    <= EMPTY;
          end else if (w_accept) begin
            // Decode is stalled: park the newcomer behind OUT.
            r_skid_pc   <= if_pc_i;
            r_skid_inst <= if_inst_i;
            r_state     <= FULL;
          end
        end
        FULL: begin
          if (w_consume) begin
            r_out_pc    <= r_skid_pc;
            r_out_inst  <= r_skid_inst;
            r_skid_pc   <= '0;
            r_skid_inst <= '0;
            r_state     <= ONE;
          end
        end
        default: r_state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_if_id_buffer.sv
module tb_if_id_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid_i;
  logic [31:0] if_pc_i;
  logic [63:0] if_inst_i;
  logic        if_ready_o;
  logic        stall_i;
  logic        flush_i;
  logic        id_valid_o;
  logic [31:0] id_pc_o;
  logic [63:0] id_inst_o;

  if_id_buffer dut (
    .clk        (clk),
    .rst        (rst),
    .if_valid_i (if_valid_i),
    .if_pc_i    (if_pc_i),
    .if_inst_i  (if_inst_i),
    .if_ready_o (if_ready_o),
    .stall_i    (stall_i),
    .flush_i    (flush_i),
    .id_valid_o (id_valid_o),
    .id_pc_o    (id_pc_o),
    .id_inst_o  (id_inst_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [63:0] inst;
  } ent_t;

  ent_t sb[$];
  int   npass  = 0;
  int   ntotal = 0;

  localparam logic [63:0] IA = 64'h1100_0000_0000_00AA;
  localparam logic [63:0] IB = 64'h2200_0000_0000_00BB;
  localparam logic [63:0] IC = 64'h3300_0000_0000_00CC;
  localparam logic [63:0] ID = 64'h4400_0000_0000_00DD;
  localparam logic [63:0] IE = 64'h5500_0000_0000_00EE;
  localparam logic [63:0] IX = 64'h6600_0000_0000_0099;

  // One clock of stimulus, starting and ending at a falling edge. The
  // scoreboard tracks what the buffer should hold after the rising edge.
  task automatic cyc(input logic v, input logic [31:0] pc, input logic [63:0] inst,
                     input logic st, input logic fl);
    bit   acc, con;
    ent_t e;
    if_valid_i = v; if_pc_i = pc; if_inst_i = inst; stall_i = st; flush_i = fl;
    acc = v && (sb.size() < 2);
    con = (sb.size() > 0) && !st;
    @(posedge clk);
    if (fl) sb.delete();
    else begin
      if (con) sb.delete(0);
      if (acc) begin e.pc = pc; e.inst = inst; sb.push_back(e); end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; if_valid_i = 1'b1; if_pc_i = 32'h44; if_inst_i = IX;
    stall_i = 1'b0; flush_i = 1'b0;
    repeat (3) @(negedge clk);
    ntotal++;
    if ({id_valid_o, id_pc_o, id_inst_o} !== 97'd0)
      $display("FAIL reset_outputs: got %b/%h/%h want 0/0/0", id_valid_o, id_pc_o, id_inst_o);
    else npass++;
    ntotal++;
    if (if_ready_o !== 1'b0) $display("FAIL reset_ready: got %b want 0", if_ready_o);
    else npass++;
    rst = 1'b0; if_valid_i = 1'b0;
    #1;
    ntotal++;
    if (if_ready_o !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", if_ready_o);
    else npass++;
    @(negedge clk);
  endtask

  task automatic test_stream();
    cyc(1, 32'h0, IA, 0, 0);
    ntotal++;
    if ({id_valid_o, id_pc_o, id_inst_o} !== {1'b1, 32'h0, IA})
      $display("FAIL stream_A: got %b/%h/%h want 1/0/%h", id_valid_o, id_pc_o, id_inst_o, IA);
    else npass++;
    cyc(1, 32'h8, IB, 0, 0);
    ntotal++;
    if ({id_valid_o, id_pc_o, id_inst_o} !== {1'b1, 32'h8, IB})
      $display("FAIL stream_B: got %b/%h/%h want 1/8/%h", id_valid_o, id_pc_o, id_inst_o, IB);
    else npass++;
    cyc(1, 32'h10, IC, 0, 0);
    ntotal++;
    if ({id_valid_o, id_pc_o, id_inst_o} !== {1'b1, 32'h10, IC})
      $display("FAIL stream_C: got %b/%h/%h want 1/10/%h", id_valid_o, id_pc_o, id_inst_o, IC);
    else npass++;
    ntotal++;
    if (if_ready_o !== 1'b1) $display("FAIL stream_ready: got %b want 1", if_ready_o);
    else npass++;
    cyc(0, 32'h0, 64'h0, 0, 0);
    ntotal++;
    if ({id_valid_o, id_pc_o, id_inst_o} !== 97'd0)
      $display("FAIL stream_drain: got %b/%h/%h want 0/0/0", id_valid_o, id_pc_o, id_inst_o);
    else npass++;
  endtask

  task automatic test_skid();
    cyc(1, 32'h20, IA, 0, 0);
    cyc(1, 32'h28, IB, 1, 0);
    ntotal++;
    if ({id_valid_o, id_pc_o, id_inst_o} !== {1'b1, 32'h20, IA})
      $display("FAIL skid_hold_A: got %b/%h/%h want 1/20/%h", id_valid_o, id_pc_o, id_inst_o, IA);
    else npass++;
    ntotal++;
    if (if_ready_o !== 1'b0) $display("FAIL skid_full_ready: got %b want 0", if_ready_o);
    else npass++;
    cyc(0, 32'h0, 64'h0, 0, 0);
    ntotal++;
    if ({id_valid_o, id_pc_o, id_inst_o} !== {1'b1, 32'h28, IB})
      $display("FAIL skid_out_B: got %b/%h/%h want 1/28/%h", id_valid_o, id_pc_o, id_inst_o, IB);
    else npass++;
    ntotal++;
    if (if_ready_o !== 1'b1) $display("FAIL skid_release_ready: got %b want 1", if_ready_o);
    else npass++;
    cyc(0, 32'h0, 64'h0, 0, 0);
    ntotal++;
    if (id_valid_o !== 1'b0) $display("FAIL skid_drain: got %b want 0", id_valid_o);
    else npass++;
  endtask

  task automatic test_flush_full();
    cyc(1, 32'h30, IA, 1, 0);
    cyc(1, 32'h38, IB, 1, 0);
    cyc(1, 32'h40, ID, 0, 1);
    ntotal++;
    if ({id_valid_o, id_pc_o, id_inst_o} !== 97'd0)
      $display("FAIL flush_outputs: got %b/%h/%h want 0/0/0", id_valid_o, id_pc_o, id_inst_o);
    else npass++;
    ntotal++;
    if (if_ready_o !== 1'b1) $display("FAIL flush_ready: got %b want 1", if_ready_o);
    else npass++;
    for (int k = 0; k < 2; k++) begin
      cyc(0, 32'h0, 64'h0, 0, 0);
      ntotal++;
      if ({id_valid_o, id_pc_o, id_inst_o} !== 97'd0)
        $display("FAIL flush_no_D: got %b/%h/%h want 0/0/0", id_valid_o, id_pc_o, id_inst_o);
      else npass++;
    end
  endtask

  task automatic test_async_reset();
    cyc(1, 32'h50, IA, 1, 0);
    cyc(1, 32'h58, IB, 1, 0);
    if_valid_i = 1'b0; stall_i = 1'b1;
    #2 rst = 1'b1;
    #1;
    ntotal++;
    if ({id_valid_o, id_pc_o, id_inst_o} !== 97'd0)
      $display("FAIL areset_outputs: got %b/%h/%h want 0/0/0", id_valid_o, id_pc_o, id_inst_o);
    else npass++;
    ntotal++;
    if (if_ready_o !== 1'b0) $display("FAIL areset_ready: got %b want 0", if_ready_o);
    else npass++;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    cyc(1, 32'h60, IE, 0, 0);
    ntotal++;
    if ({id_valid_o, id_pc_o, id_inst_o} !== {1'b1, 32'h60, IE})
      $display("FAIL areset_first: got %b/%h/%h want 1/60/%h", id_valid_o, id_pc_o, id_inst_o, IE);
    else npass++;
    cyc(0, 32'h0, 64'h0, 0, 0);
  endtask

  task automatic test_long_stall();
    cyc(1, 32'h70, IA, 1, 0);
    cyc(1, 32'h78, IB, 1, 0);
    for (int k = 0; k < 5; k++) begin
      cyc(1, 32'h80 + k, IX, 1, 0);
      ntotal++;
      if ({id_valid_o, id_pc_o, id_inst_o, if_ready_o} !== {1'b1, 32'h70, IA, 1'b0})
        $display("FAIL long_stall: got %b/%h/%h rdy %b want 1/70/%h rdy 0",
                 id_valid_o, id_pc_o, id_inst_o, if_ready_o, IA);
      else npass++;
    end
    cyc(0, 32'h0, 64'h0, 0, 0);
    ntotal++;
    if ({id_valid_o, id_pc_o, id_inst_o} !== {1'b1, 32'h78, IB})
      $display("FAIL long_stall_B: got %b/%h/%h want 1/78/%h", id_valid_o, id_pc_o, id_inst_o, IB);
    else npass++;
    cyc(0, 32'h0, 64'h0, 0, 0);
    ntotal++;
    if (id_valid_o !== 1'b0) $display("FAIL long_stall_noX: got %b want 0", id_valid_o);
    else npass++;
  endtask

  task automatic test_random();
    logic [96:0] exp;
    int          nfail_local = 0;
    for (int i = 0; i < 10000; i++) begin
      cyc($urandom_range(0, 9) < 7, 32'(i) << 3, {$urandom, $urandom},
          $urandom_range(0, 9) < 3, $urandom_range(0, 99) < 3);
      exp = (sb.size() > 0) ? {1'b1, sb[0].pc, sb[0].inst} : 97'd0;
      ntotal++;
      if ({id_valid_o, id_pc_o, id_inst_o} !== exp) begin
        if (nfail_local < 10)
          $display("FAIL random_out cyc %0d: got %b/%h/%h want %b/%h/%h", i,
                   id_valid_o, id_pc_o, id_inst_o, exp[96], exp[95:64], exp[63:0]);
        nfail_local++;
      end else npass++;
      ntotal++;
      if (if_ready_o !== (sb.size() < 2)) begin
        if (nfail_local < 10)
          $display("FAIL random_ready cyc %0d: got %b want %b", i, if_ready_o, sb.size() < 2);
        nfail_local++;
      end else npass++;
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_skid();
    test_flush_full();
    test_async_reset();
    test_long_stall();
    test_random();
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
